// File: rtl/deint_pkg.sv
// rtl/deint_pkg.sv - shared state encoding, modulation codes and drain targets
// Purpose: common definitions for deint_ctrl and deint_drain_cnt.
// Ports: none (package).
package deint_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MOD_BPSK  = 2'd0;
  localparam logic [1:0] MOD_QPSK  = 2'd1;
  localparam logic [1:0] MOD_16QAM = 2'd2;
  localparam logic [1:0] MOD_64QAM = 2'd3;

  localparam int CNT_W = 8;

  // N_CBPS/2: two lanes per run cycle, so half the coded bits per symbol.
  function automatic logic [CNT_W-1:0] drain_target(input logic [1:0] mod);
    logic [CNT_W-1:0] t;
    t = 8'd24;
    case (mod)
      MOD_BPSK:  t = 8'd24;
      MOD_QPSK:  t = 8'd48;
      MOD_16QAM: t = 8'd96;
      MOD_64QAM: t = 8'd144;
      default:   t = 8'd24;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/deint_drain_cnt.sv
// rtl/deint_drain_cnt.sv - deinterleaver valid-cycle counter with terminal compare
// Purpose: counts deint_valid cycles per symbol and flags the cycle that reaches
//          the modulation-dependent target.
// Ports: clk, rst (async, active-low), i_clr (clear on acceptance),
//        i_en (count window), i_valid (deinterleaver valid), i_mod (latched mod),
//        o_hit (this cycle's valid completes the target).
module deint_drain_cnt
  import deint_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_valid,
  input  logic [1:0] i_mod,
  output logic       o_hit
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_tgt;
  logic             w_full;

  assign w_tgt  = drain_target(i_mod);
  assign w_full = (r_cnt == w_tgt);
  // Hit is raised on the valid cycle itself, so DRAIN leaves without a wasted cycle.
  assign o_hit  = i_en && i_valid && (r_cnt == (w_tgt - 8'd1));

  // Saturates at the target so a misbehaving deinterleaver cannot wrap it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && i_valid && !w_full) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/deint_ctrl.sv
// rtl/deint_ctrl.sv - OFDM symbol deinterleaver sequencing controller
// Purpose: accepts a symbol request, reads RUN_CYC buffer words into the
//          deinterleaver, then waits for the mod-dependent number of valid
//          cycles before signalling completion.
// Ports: clk, rst (async, active-low); sym_req/sym_mod/sym_ack request side;
//        rd_en/rd_addr/rd_data0/rd_data1 symbol buffer; x0/x1/run/deint_mod/
//        deint_valid deinterleaver side; busy/sym_done/err status.
module deint_ctrl
  import deint_pkg::*;
#(
  parameter int RUN_CYC = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sym_req,
  input  logic [1:0]  sym_mod,
  output logic        sym_ack,
  output logic        rd_en,
  output logic [2:0]  rd_addr,
  input  logic [17:0] rd_data0,
  input  logic [17:0] rd_data1,
  output logic [17:0] x0,
  output logic [17:0] x1,
  output logic        run,
  output logic [1:0]  deint_mod,
  input  logic        deint_valid,
  output logic        busy,
  output logic        sym_done,
  output logic        err
);

  localparam logic [2:0] LAST_ADDR = 3'(RUN_CYC - 1);

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_addr;
  logic       r_run;
  logic [1:0] r_mod;
  logic       r_err;
  logic       w_accept;
  logic       w_hit;
  logic       w_cnt_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    rd_en    = 1'b0;
    busy     = 1'b1;
    sym_done = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        // rst gating keeps the combinational ack quiet while reset is held.
        if (sym_req && rst) begin
          w_accept = 1'b1;
          w_next   = READ;
        end
      end
      READ: begin
        rd_en = 1'b1;
        if (r_addr == LAST_ADDR) w_next = DRAIN;
      end
      DRAIN: begin
        if (w_hit) w_next = DONE;
      end
      DONE: begin
        sym_done = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr <= '0;
      r_run  <= 1'b0;
      r_mod  <= MOD_BPSK;
      r_err  <= 1'b0;
    end else begin
      r_run <= rd_en;
      if (r_state == READ) r_addr <= (r_addr == LAST_ADDR) ? 3'd0 : r_addr + 3'd1;
      if (w_accept) r_mod <= sym_mod;
      if ((w_cnt_en && !deint_valid) || ((r_state == IDLE) && deint_valid)) r_err <= 1'b1;
    end
  end

  // Counting starts with the first run cycle, which follows the first read by one.
  assign w_cnt_en = r_run || (r_state == DRAIN);

  deint_drain_cnt u_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_accept),
    .i_en    (w_cnt_en),
    .i_valid (deint_valid),
    .i_mod   (r_mod),
    .o_hit   (w_hit)
  );

  assign sym_ack   = w_accept;
  assign rd_addr   = r_addr;
  assign run       = r_run;
  assign x0        = rd_data0;
  assign x1        = rd_data1;
  assign deint_mod = r_mod;
  assign err       = r_err;

endmodule

// File: tb/tb_deint_ctrl.sv
// tb/tb_deint_ctrl.sv - self-checking bench for deint_ctrl
module tb_deint_ctrl;

  logic        clk;
  logic        rst;
  logic        sym_req;
  logic [1:0]  sym_mod;
  logic        sym_ack;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic [17:0] rd_data0;
  logic [17:0] rd_data1;
  logic [17:0] x0;
  logic [17:0] x1;
  logic        run;
  logic [1:0]  deint_mod;
  logic        deint_valid;
  logic        busy;
  logic        sym_done;
  logic        err;

  int    n_cmp = 0;
  int    n_bad = 0;
  string cur_tag = "";

  deint_ctrl #(.RUN_CYC(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .sym_req     (sym_req),
    .sym_mod     (sym_mod),
    .sym_ack     (sym_ack),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data0    (rd_data0),
    .rd_data1    (rd_data1),
    .x0          (x0),
    .x1          (x1),
    .run         (run),
    .deint_mod   (deint_mod),
    .deint_valid (deint_valid),
    .busy        (busy),
    .sym_done    (sym_done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mod;
    int         tgt;
    int         drop_at;
    bit         toggle;
    int         exp_mod;
    int         exp_err;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s/%s: got %0d expected %0d", cur_tag, name, act, exp_v);
    end
  endtask

  function automatic int outs();
    return int'({sym_ack, rd_en, run, busy, sym_done, err, rd_addr, deint_mod});
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; sym_req = 1'b0; deint_valid = 1'b0;
    #1;
    check("rst_outs", outs(), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One symbol with ack expected at cycle 0; the bench plays the deinterleaver.
  task automatic run_symbol(input vec_t v);
    int d, exp_done;
    int n_ack, ack_cyc, rd_cnt, rd_first, rd_last, addr_bad;
    int run_cnt, run_first, run_last, x_bad, done_cnt, done_cyc, busy_bad, mod_bad;
    d = (v.drop_at >= 0) ? 1 : 0;
    exp_done = 2 + v.tgt + d;
    n_ack = 0; ack_cyc = -1; rd_cnt = 0; rd_first = -1; rd_last = -1; addr_bad = 0;
    run_cnt = 0; run_first = -1; run_last = -1; x_bad = 0;
    done_cnt = 0; done_cyc = -1; busy_bad = 0; mod_bad = 0;
    for (int c = 0; c <= exp_done + 2; c++) begin
      @(negedge clk);
      sym_req     = (c == 0);
      sym_mod     = (v.toggle && c >= 3) ? 2'd0 : v.mod;
      deint_valid = (c >= 2 && c <= 1 + v.tgt + d && c != v.drop_at);
      rd_data0    = 18'(c * 3 + 1);
      rd_data1    = 18'(c * 7 + 5);
      #1;
      if (sym_ack) begin n_ack++; if (ack_cyc < 0) ack_cyc = c; end
      if (rd_en) begin
        rd_cnt++; if (rd_first < 0) rd_first = c; rd_last = c;
        if (int'(rd_addr) != c - 1) addr_bad++;
      end
      if (run) begin
        run_cnt++; if (run_first < 0) run_first = c; run_last = c;
        if (x0 != rd_data0 || x1 != rd_data1) x_bad++;
      end
      if (sym_done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
      if (busy != (c >= 1 && c <= exp_done)) busy_bad++;
      if (c >= 1 && int'(deint_mod) != v.exp_mod) mod_bad++;
    end
    sym_req = 1'b0; deint_valid = 1'b0;
    check("n_ack", n_ack, 1);
    check("ack_cyc", ack_cyc, 0);
    check("rd_cnt", rd_cnt, 8);
    check("rd_first", rd_first, 1);
    check("rd_last", rd_last, 8);
    check("addr_bad", addr_bad, 0);
    check("run_cnt", run_cnt, 8);
    check("run_first", run_first, 2);
    check("run_last", run_last, 9);
    check("x_bad", x_bad, 0);
    check("done_cnt", done_cnt, 1);
    check("done_cyc", done_cyc, exp_done);
    check("busy_bad", busy_bad, 0);
    check("mod_bad", mod_bad, 0);
    check("err", int'(err), v.exp_err);
  endtask

  initial begin
    rst = 1'b0; sym_req = 1'b0; sym_mod = 2'd0; deint_valid = 1'b0;
    rd_data0 = '0; rd_data1 = '0;

    //         mod   tgt  drop toggle exp_mod exp_err
    vecs[0] = '{2'd3, 144, -1,  1'b0,  3,      0};
    vecs[1] = '{2'd0, 24,  -1,  1'b0,  0,      0};
    vecs[2] = '{2'd1, 48,  -1,  1'b0,  1,      0};
    vecs[3] = '{2'd2, 96,  -1,  1'b0,  2,      0};
    vecs[4] = '{2'd3, 144, 40,  1'b0,  3,      1};
    vecs[5] = '{2'd2, 96,  5,   1'b0,  2,      1};
    vecs[6] = '{2'd3, 144, -1,  1'b1,  3,      0};

    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      cur_tag = $sformatf("vec%0d", i);
      do_reset();
      run_symbol(vecs[i]);
    end

    // Request held high: back-to-back 16QAM symbols.
    begin
      int acks [3];
      int dones [3];
      int na, nd, last_ack, ack_busy, coincide;
      cur_tag = "b2b";
      do_reset();
      na = 0; nd = 0; last_ack = -1000; ack_busy = 0; coincide = 0;
      for (int k = 0; k < 3; k++) begin acks[k] = -1; dones[k] = -1; end
      for (int c = 0; c < 400 && nd < 3; c++) begin
        @(negedge clk);
        sym_req = 1'b1; sym_mod = 2'd2;
        deint_valid = (c - last_ack >= 2 && c - last_ack <= 97);
        #1;
        if (sym_ack) begin
          if (busy) ack_busy++;
          if (sym_done) coincide++;
          if (na < 3) acks[na] = c;
          na++; last_ack = c;
        end
        if (sym_done) begin
          if (nd < 3) dones[nd] = c;
          nd++;
        end
      end
      sym_req = 1'b0; deint_valid = 1'b0;
      check("n_ack", na, 3);
      check("n_done", nd, 3);
      check("ack_busy", ack_busy, 0);
      check("coincide", coincide, 0);
      check("ack0", acks[0], 0);
      for (int k = 0; k < 3; k++) check($sformatf("len%0d", k), dones[k] - acks[k], 98);
      for (int k = 0; k < 2; k++) check($sformatf("gap%0d", k), acks[k+1] - dones[k], 1);
      check("err", int'(err), 0);
    end

    // Reset on the 4th READ cycle, then a clean QPSK symbol.
    begin
      int done_seen;
      cur_tag = "midrst";
      do_reset();
      done_seen = 0;
      @(negedge clk);
      sym_req = 1'b1; sym_mod = 2'd3;
      #1;
      check("ack", int'(sym_ack), 1);
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        sym_req = 1'b0;
        deint_valid = (c >= 2);
        #1;
      end
      check("rd_addr_pre", int'(rd_addr), 3);
      check("rd_en_pre", int'(rd_en), 1);
      rst = 1'b0; sym_req = 1'b1;
      #1;
      check("outs_in_rst", outs(), 0);
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        #1;
        if (sym_done) done_seen++;
      end
      check("outs_held", outs(), 0);
      check("no_done", done_seen, 0);
      sym_req = 1'b0; deint_valid = 1'b0; rst = 1'b1;
      run_symbol('{2'd1, 48, -1, 1'b0, 1, 0});
    end

    // Valid while idle must raise a sticky error.
    cur_tag = "idle_valid";
    do_reset();
    @(negedge clk);
    deint_valid = 1'b1;
    #1;
    check("err_pre", int'(err), 0);
    @(negedge clk);
    deint_valid = 1'b0;
    #1;
    check("err_set", int'(err), 1);
    @(negedge clk);
    #1;
    check("err_sticky", int'(err), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
